// File: rtl/dpram_frame_reader.sv
// dpram_frame_reader
//   Replays one captured frame from the sample DPRAM as a valid/ready stream.
//   Reading starts at an arbitrary trigger pointer and wraps circularly
//   through the 2**ADDR_W buffer. A small output FIFO hides the RAM read
//   latency and absorbs downstream back-pressure. Reads are only issued when
//   the FIFO is guaranteed to have room for the returning data (credit check).
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            1-clk pulse: begin a frame (ignored while busy or with abort)
//   start_addr       first RAM address of the frame
//   frame_len        number of beats, 0..2**ADDR_W
//   abort            cancel the frame in progress (no done pulse)
//   busy             frame active
//   done             1-clk pulse after the last beat handshakes
//   ram_rd_en        DPRAM read enable
//   ram_addr         DPRAM read address
//   ram_rd_data      DPRAM read data, valid RD_LATENCY clks after ram_rd_en
//   m_data/m_valid/m_ready/m_last   output stream
module dpram_frame_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 10,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]            state_reg;
  logic [ADDR_W-1:0]     base_reg;
  logic [ADDR_W:0]       len_reg;
  logic [ADDR_W:0]       issued_reg;
  logic [ADDR_W:0]       beat_reg;
  logic                  done_reg;

  logic [RD_LATENCY-1:0] pipe_reg;
  logic [RD_LATENCY-1:0] pipe_next;
  logic [CNT_W-1:0]      inflight_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [DATA_W-1:0]     fifo_mem [FIFO_DEPTH];

  logic                  accept;
  logic                  ret;
  logic                  pop;
  logic                  last_beat;
  logic [CNT_W:0]        occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // abort beats start when both arrive in the same clock
  assign accept = (state_reg == ST_IDLE) && start && !abort;

  // FIFO slots already promised = stored entries + reads still in the RAM pipe
  assign occupancy = {1'b0, count_reg} + {1'b0, inflight_reg};

  assign ram_rd_en = (state_reg == ST_READ) && !abort && (issued_reg != len_reg) &&
                     (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  // truncation to ADDR_W bits gives the circular wrap
  assign ram_addr  = base_reg + issued_reg[ADDR_W-1:0];

  // issue-tracking shift register: bit RD_LATENCY-1 marks data present on ram_rd_data
  assign pipe_next[0] = ram_rd_en;
  for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_pipe
    assign pipe_next[gi] = pipe_reg[gi-1];
  end
  assign ret = pipe_reg[RD_LATENCY-1];

  assign m_valid   = (count_reg != '0);
  assign m_data    = fifo_mem[rd_ptr_reg];
  assign m_last    = m_valid && (beat_reg == len_reg - LEN_ONE);
  assign pop       = m_valid && m_ready;
  assign last_beat = pop && m_last;

  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;

  // frame control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      base_reg   <= '0;
      len_reg    <= '0;
      issued_reg <= '0;
      beat_reg   <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (pop) begin
        beat_reg <= beat_reg + LEN_ONE;
      end
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (frame_len == '0) begin
              done_reg <= 1'b1;
            end else begin
              state_reg  <= ST_READ;
              base_reg   <= start_addr;
              len_reg    <= frame_len;
              issued_reg <= '0;
              beat_reg   <= '0;
            end
          end
        end
        ST_READ: begin
          if (abort) begin
            state_reg <= ST_IDLE;
          end else if (ram_rd_en) begin
            issued_reg <= issued_reg + LEN_ONE;
            if (issued_reg == len_reg - LEN_ONE) begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state_reg <= ST_IDLE;
          end else if (last_beat) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // read-return tracking and output FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_reg     <= '0;
      inflight_reg <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (abort && (state_reg != ST_IDLE)) begin
      // drop stored beats and forget reads still coming back from the RAM
      pipe_reg     <= '0;
      inflight_reg <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      pipe_reg <= pipe_next;
      case ({ram_rd_en, ret})
        2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
        2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
        default: inflight_reg <= inflight_reg;
      endcase
      case ({ret, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (ret) begin
        fifo_mem[wr_ptr_reg] <= ram_rd_data;
        wr_ptr_reg           <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
    end
  end

endmodule
